load_store_unit: RTL and testbench

- Sits between the pipeline's MEM stage (EX/MEM latches: ALU address, store data, funct3, MemRead/MemWrite) and a ready/valid data bus.
- Replaces the zero-latency data memory access with a multi-cycle access:
  - byte/half/word stores with byte strobes;
  - loads with sign/zero extension.
- Stalls the pipeline while an access is outstanding.
- Flags misaligned accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 78 +++++++
 rtl/load_store_unit_align.sv | 24 ++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit types and helpers.
// Width codes, FSM states, strobe/data/extend/misalign functions.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  function automatic logic [3:0] st_strb(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow data is replicated so every lane carries it.
  function automatic logic [31:0] st_data(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] w
  );
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{s[7]}}, s[7:0]};
      F3_BU:   return {24'b0, s[7:0]};
      F3_H:    return {{16{s[15]}}, s[15:0]};
      F3_HU:   return {16'b0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Bad width codes are rejected the same way as misaligned ones.
  function automatic logic bad_acc(
    input logic [2:0] f3,
    input logic [1:0] off,
    input logic       we
  );
    logic ok;
    logic mis;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off;
      default: mis = 1'b0;
    endcase
    return !ok || mis;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational store shift/strobe, load extract/extend, misalign check.
// Store side uses live request; load side uses captured request.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        bad_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  assign wstrb_o = st_strb(f3_i, off_i);
  assign wdata_o = st_data(f3_i, wdata_i);
  assign bad_o   = bad_acc(f3_i, off_i, we_i);
  assign ldata_o = ld_ext(ld_f3_i, ld_off_i, rdata_i);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between MEM stage and ready/valid bus.
// Ports: pipeline req/stall/load result, bus req/rsp, error pulses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              bus_error,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rdata
);

  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  lsu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [3:0]        strb_q;
  logic [31:0]       wd_q;
  logic [31:0]       ld_q;

  logic        req, bad, req_ok, busy, tmo, hs, cap;
  logic [3:0]  strb_n;
  logic [31:0] wd_n, ld_n;

  lsu_align u_align (
    .f3_i     (funct3),
    .off_i    (addr[1:0]),
    .we_i     (mem_write),
    .wdata_i  (wdata),
    .wstrb_o  (strb_n),
    .wdata_o  (wd_n),
    .bad_o    (bad),
    .ld_f3_i  (f3_q),
    .ld_off_i (addr_q[1:0]),
    .rdata_i  (bus_rdata),
    .ldata_o  (ld_n)
  );

  assign req    = !rst && state_q == IDLE && (mem_read || mem_write);
  assign req_ok = req && !bad;
  assign busy   = state_q == REQ || state_q == WAIT;
  assign tmo    = !rst && (TIMEOUT != 0) && busy
                  && cnt_q == CW'(TLIM);
  assign hs     = bus_req_valid && bus_req_ready;

  assign bus_req_valid = !rst && state_q == REQ && !tmo;
  assign stall         = req_ok || (!rst && busy && !tmo);
  assign misaligned    = req && bad;
  assign bus_error     = tmo;
  assign load_valid    = !rst && state_q == DONE && !we_q;
  assign load_data     = ld_q;
  assign bus_we        = we_q;
  assign bus_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wstrb     = strb_q;
  assign bus_wdata     = wd_q;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (req_ok) state_d = REQ;
      REQ: begin
        if (tmo) begin
          state_d = IDLE;
        end else if (hs) begin
          // Zero-wait bus: response in the handshake cycle.
          state_d = bus_rsp_valid ? DONE : WAIT;
          cap     = bus_rsp_valid && !we_q;
        end
      end
      WAIT: begin
        if (tmo) begin
          state_d = IDLE;
        end else if (bus_rsp_valid) begin
          state_d = DONE;
          cap     = !we_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (busy && state_d == state_q) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      wd_q    <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_ok) begin
        addr_q <= addr;
        f3_q   <= funct3;
        we_q   <= mem_write;
        strb_q <= strb_n;
        wd_q   <= wd_n;
      end
      if (cap) ld_q <= ld_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit.
// Hand sequences cover reset state and reset during WAIT.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_req_ready = 1'b0;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall, load_valid, misaligned, bus_error;
  logic        bus_req_valid, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  int total = 0;
  int bad = 0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .misaligned    (misaligned),
    .bus_error     (bus_error),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy;
    int          rsp;
    int          e_stall;
    int          e_lv;
    logic [31:0] e_ld;
    int          e_mis;
    int          e_err;
    int          e_req;
    logic        e_we;
    logic [31:0] e_baddr;
    logic [3:0]  e_strb;
    logic [31:0] e_bwd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Cycle 0 is the request cycle; ready/rsp are pulsed on
  // fixed cycles. Requests stay held until stall is seen low.
  task automatic run_vec(input int idx, input vec_t v);
    int hs_c, rsp_c;
    int st_n, lv_n, mis_n, err_n, req_n, unst;
    logic [31:0] ld_seen, prev_ld;
    logic [68:0] snap, cur;
    logic done;
    string p;
    p = $sformatf("v%0d", idx);
    hs_c  = (v.rdy == 255) ? -1 : 1 + v.rdy;
    rsp_c = (hs_c < 0 || v.rsp == 255) ? -1 : hs_c + v.rsp;
    st_n = 0; lv_n = 0; mis_n = 0; err_n = 0; req_n = 0;
    unst = 0; ld_seen = '0; snap = '0; done = 1'b0;
    @(posedge clk); #1;
    mem_read  = v.rd;
    mem_write = v.wr;
    funct3    = v.f3;
    addr      = v.addr;
    wdata     = v.wdata;
    bus_rdata = v.rdata;
    prev_ld   = load_data;
    for (int c = 0; c < 40 && !done; c++) begin
      bus_req_ready = (c == hs_c);
      bus_rsp_valid = (c == rsp_c);
      @(negedge clk);
      if (stall) st_n++;
      if (misaligned) mis_n++;
      if (bus_error) err_n++;
      if (load_valid) begin
        lv_n++;
        ld_seen = load_data;
      end else if (load_data !== prev_ld) begin
        unst = 1;
      end
      prev_ld = load_data;
      cur = {bus_we, bus_addr, bus_wstrb, bus_wdata};
      if (bus_req_valid) begin
        if (req_n == 0) snap = cur;
        else if (cur !== snap) unst = 1;
        req_n++;
      end
      if (!stall) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s finish: stall still high after 40 cycles", p);
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    chk({p, " stall"}, st_n, v.e_stall);
    chk({p, " lv"}, lv_n, v.e_lv);
    chk({p, " mis"}, mis_n, v.e_mis);
    chk({p, " err"}, err_n, v.e_err);
    chk({p, " req"}, req_n, v.e_req);
    chk({p, " stable"}, unst, 0);
    if (v.e_lv != 0) chk({p, " ldata"}, ld_seen, v.e_ld);
    if (v.e_req != 0) begin
      chk({p, " we"}, 32'(snap[68]), 32'(v.e_we));
      chk({p, " baddr"}, snap[67:36], v.e_baddr);
      if (v.e_we) begin
        chk({p, " strb"}, 32'(snap[35:32]), 32'(v.e_strb));
        chk({p, " bwdata"}, snap[31:0], v.e_bwd);
      end
    end
  endtask

  localparam logic [31:0] RD = 32'h80F1_7F01;

  initial begin
    int n;
    // SW / SB / SH: strobes and lane replication
    vt.push_back('{0,1,3'd2,32'h100,32'hDEADBEEF,0,0,0,
                   2,0,0,0,0,1,1,32'h100,4'hF,32'hDEADBEEF});
    vt.push_back('{0,1,3'd0,32'h103,32'h000000A5,0,0,0,
                   2,0,0,0,0,1,1,32'h100,4'h8,32'hA5A5A5A5});
    vt.push_back('{0,1,3'd1,32'h102,32'h1234BEEF,0,0,0,
                   2,0,0,0,0,1,1,32'h100,4'hC,32'hBEEFBEEF});
    vt.push_back('{0,1,3'd0,32'h001,32'h12345677,0,0,0,
                   2,0,0,0,0,1,1,32'h000,4'h2,32'h77777777});
    // loads: extraction and extension
    vt.push_back('{1,0,3'd0,32'h1,0,RD,0,0,
                   2,1,32'h0000007F,0,0,1,0,32'h0,4'h0,0});
    vt.push_back('{1,0,3'd0,32'h3,0,RD,0,0,
                   2,1,32'hFFFFFF80,0,0,1,0,32'h0,4'h0,0});
    vt.push_back('{1,0,3'd4,32'h3,0,RD,0,0,
                   2,1,32'h00000080,0,0,1,0,32'h0,4'h0,0});
    vt.push_back('{1,0,3'd1,32'h2,0,RD,0,0,
                   2,1,32'hFFFF80F1,0,0,1,0,32'h0,4'h0,0});
    vt.push_back('{1,0,3'd5,32'h2,0,RD,0,0,
                   2,1,32'h000080F1,0,0,1,0,32'h0,4'h0,0});
    vt.push_back('{1,0,3'd1,32'h0,0,RD,0,0,
                   2,1,32'h00007F01,0,0,1,0,32'h0,4'h0,0});
    // slow bus: ready after 3 cycles, rsp 4 cycles later
    vt.push_back('{1,0,3'd2,32'h104,0,RD,3,4,
                   9,1,32'h80F17F01,0,0,4,0,32'h104,4'h0,0});
    vt.push_back('{1,0,3'd0,32'h1,0,32'h0000FF00,1,1,
                   4,1,32'hFFFFFFFF,0,0,2,0,32'h0,4'h0,0});
    vt.push_back('{0,1,3'd2,32'h20,32'h01234567,0,0,2,
                   4,0,0,0,0,1,1,32'h20,4'hF,32'h01234567});
    // misaligned / illegal width
    vt.push_back('{1,0,3'd2,32'h102,0,RD,0,0,
                   0,0,0,1,0,0,0,0,4'h0,0});
    vt.push_back('{0,1,3'd1,32'h101,32'h5555,0,0,0,
                   0,0,0,1,0,0,0,0,4'h0,0});
    vt.push_back('{1,0,3'd3,32'h0,0,RD,0,0,
                   0,0,0,1,0,0,0,0,4'h0,0});
    vt.push_back('{0,1,3'd4,32'h0,32'h1,0,0,0,
                   0,0,0,1,0,0,0,0,4'h0,0});
    vt.push_back('{1,0,3'd6,32'h0,0,RD,0,0,
                   0,0,0,1,0,0,0,0,4'h0,0});
    // read+write together is a write
    vt.push_back('{1,1,3'd2,32'h200,32'hCAFEF00D,RD,0,0,
                   2,0,0,0,0,1,1,32'h200,4'hF,32'hCAFEF00D});
    // timeouts: never ready; ready but never responds
    vt.push_back('{1,0,3'd2,32'h10,0,RD,255,255,
                   8,0,0,0,1,7,0,32'h10,4'h0,0});
    vt.push_back('{0,1,3'd2,32'h14,32'h11111111,0,0,255,
                   9,0,0,0,1,1,1,32'h14,4'hF,32'h11111111});

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ctl", 32'({stall, load_valid, misaligned, bus_error,
                        bus_req_valid, bus_we, bus_wstrb}), 0);
    chk("rst ldata", load_data, 0);
    chk("rst baddr", bus_addr, 0);
    chk("rst bwdata", bus_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vt[i]) run_vec(i, vt[i]);

    // reset during WAIT, then a late response
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'd2; addr = 32'h8;
    bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_req_ready = 1'b1;
    @(negedge clk);
    chk("rw req", 32'(bus_req_valid), 1);
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    @(negedge clk);
    chk("rw wait stall", 32'(stall), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("rw rst stall", 32'({stall, bus_req_valid}), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw rst ctl", 32'({stall, load_valid, misaligned, bus_error,
                           bus_req_valid, bus_we, bus_wstrb}), 0);
    chk("rw rst ldata", load_data, 0);
    chk("rw rst baddr", bus_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rsp_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (load_valid || bus_error || stall || bus_req_valid) n++;
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
    end
    chk("rw late rsp", n, 0);
    chk("rw ldata hold", load_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
